// File: rtl/eer_rl_pkg.sv
// Shared widths, sentinel values and FSM state encoding for the cluster-head
// advertisement table.
package eer_rl_pkg;

    localparam int unsigned ID_W       = 8;
    localparam int unsigned Q_W        = 16;
    localparam int unsigned HOP_W      = 8;
    localparam int unsigned AGE_W      = 8;
    localparam int unsigned NUM_CH_DEF = 4;

    // Invalid entries present these so a min-hop search never picks them.
    localparam logic [ID_W-1:0]  ID_NONE  = 8'hFF;
    localparam logic [Q_W-1:0]   Q_NONE   = 16'h0000;
    localparam logic [HOP_W-1:0] HOP_NONE = 8'hFF;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StUpdate = 2'd2
    } ch_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ch_victim_select.sv
// Combinational victim finder: lowest-index valid entry holding the maximum hop count.
module ch_victim_select
    import eer_rl_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF
) (
    input  logic [NUM_CH-1:0][HOP_W-1:0]   hops_i,
    input  logic [NUM_CH-1:0]              valid_i,
    output logic [idx_width(NUM_CH)-1:0]   victim_idx_o
);

    localparam int unsigned IDX_W = idx_width(NUM_CH);

    logic [HOP_W-1:0] best_hops;
    logic             found;

    always_comb begin
        victim_idx_o = '0;
        best_hops    = '0;
        found        = 1'b0;
        // Strict compare keeps the earliest entry on ties.
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (valid_i[i] && (!found || (hops_i[i] > best_hops))) begin
                best_hops    = hops_i[i];
                victim_idx_o = IDX_W'(i);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ch_adv_table.sv
// Cluster-head advertisement table: IDLE/SEARCH/UPDATE insert-refresh-replace engine.
// Optional per-entry aging is enabled by defining CH_TABLE_AGING_EN.
module ch_adv_table
    import eer_rl_pkg::*;
#(
    parameter int unsigned      NUM_CH    = NUM_CH_DEF,
    parameter logic [AGE_W-1:0] AGE_LIMIT = 8'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv_valid,
    output logic              adv_ready,
    input  logic [ID_W-1:0]   adv_id,
    input  logic [Q_W-1:0]    adv_q,
    input  logic [HOP_W-1:0]  adv_hops,
    input  logic              tick,
    input  logic              flush,
    output logic [ID_W-1:0]   ch_id   [0:NUM_CH-1],
    output logic [Q_W-1:0]    ch_q    [0:NUM_CH-1],
    output logic [HOP_W-1:0]  ch_hops [0:NUM_CH-1],
    output logic [NUM_CH-1:0] entry_valid,
    output logic              tbl_changed,
    output logic              adv_drop
);

    localparam int unsigned IDX_W = idx_width(NUM_CH);

    ch_state_e                   state_q, state_d;
    logic                        adv_ready_q, adv_ready_d;
    logic [ID_W-1:0]             req_id_q, req_id_d;
    logic [Q_W-1:0]              req_q_q, req_q_d;
    logic [HOP_W-1:0]            req_hops_q, req_hops_d;
    logic                        upd_drop_q, upd_drop_d;
    logic [IDX_W-1:0]            upd_idx_q, upd_idx_d;
    logic [NUM_CH-1:0]           valid_q, valid_d;
    logic [NUM_CH-1:0][ID_W-1:0] id_q, id_d;
    logic [NUM_CH-1:0][Q_W-1:0]  q_q, q_d;
    logic [NUM_CH-1:0][HOP_W-1:0] hops_q, hops_d;
    logic                        tbl_changed_q, tbl_changed_d;
    logic                        adv_drop_q, adv_drop_d;

    logic [NUM_CH-1:0]           match_vec;
    logic [IDX_W-1:0]            match_idx, free_idx, victim_idx;
    logic                        wr_en;

`ifdef CH_TABLE_AGING_EN
    logic [NUM_CH-1:0][AGE_W-1:0] age_q, age_d;
    logic                         tick_pend_q, tick_pend_d;
    logic [1:0]                   tick_inc;
    logic [AGE_W:0]               age_sum;
    logic [AGE_W-1:0]             age_sat;
`else
    logic unused_aging;
    assign unused_aging = tick ^ (^AGE_LIMIT);
`endif

    ch_victim_select #(
        .NUM_CH (NUM_CH)
    ) u_victim (
        .hops_i       (hops_q),
        .valid_i      (valid_q),
        .victim_idx_o (victim_idx)
    );

    always_comb begin
        match_vec = '0;
        match_idx = '0;
        free_idx  = '0;
        // Descending scan so the lowest index wins.
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (valid_q[i] && (id_q[i] == req_id_q)) begin
                match_vec[i] = 1'b1;
                match_idx    = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        req_id_d      = req_id_q;
        req_q_d       = req_q_q;
        req_hops_d    = req_hops_q;
        upd_drop_d    = upd_drop_q;
        upd_idx_d     = upd_idx_q;
        valid_d       = valid_q;
        id_d          = id_q;
        q_d           = q_q;
        hops_d        = hops_q;
        tbl_changed_d = 1'b0;
        adv_drop_d    = 1'b0;
        wr_en         = 1'b0;
`ifdef CH_TABLE_AGING_EN
        age_d       = age_q;
        tick_pend_d = 1'b0;
        tick_inc    = '0;
        age_sum     = '0;
        age_sat     = '0;
`endif

        unique case (state_q)
            StIdle: begin
                if (adv_valid && adv_ready_q) begin
                    req_id_d   = adv_id;
                    req_q_d    = adv_q;
                    req_hops_d = adv_hops;
                    state_d    = StSearch;
                end
            end
            StSearch: begin
                state_d    = StUpdate;
                upd_drop_d = 1'b0;
                if (req_id_q == ID_NONE) begin
                    upd_drop_d = 1'b1;
                end else if (|match_vec) begin
                    upd_idx_d = match_idx;
                end else if (!(&valid_q)) begin
                    upd_idx_d = free_idx;
                end else if (req_hops_q < hops_q[victim_idx]) begin
                    upd_idx_d = victim_idx;
                end else begin
                    upd_drop_d = 1'b1;
                end
            end
            StUpdate: begin
                state_d    = StIdle;
                wr_en      = !upd_drop_q;
                adv_drop_d = upd_drop_q;
            end
            default: state_d = StIdle;
        endcase

`ifdef CH_TABLE_AGING_EN
        tick_inc = {1'b0, tick_pend_q} + {1'b0, tick};
        // A drop pulse owns this cycle; defer the tick so an expiry cannot pulse alongside it.
        if (adv_drop_d) begin
            tick_pend_d = tick | tick_pend_q;
        end else if (tick_inc != 2'd0) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (valid_q[i]) begin
                    age_sum = {1'b0, age_q[i]} + {{(AGE_W-1){1'b0}}, tick_inc};
                    age_sat = age_sum[AGE_W] ? {AGE_W{1'b1}} : age_sum[AGE_W-1:0];
                    if (age_sat >= AGE_LIMIT) begin
                        valid_d[i]    = 1'b0;
                        age_d[i]      = '0;
                        tbl_changed_d = 1'b1;
                    end else begin
                        age_d[i] = age_sat;
                    end
                end
            end
        end
`endif

        // Applied after aging so a same-cycle write on an expiring entry wins.
        if (wr_en) begin
            valid_d[upd_idx_q] = 1'b1;
            id_d[upd_idx_q]    = req_id_q;
            q_d[upd_idx_q]     = req_q_q;
            hops_d[upd_idx_q]  = req_hops_q;
            tbl_changed_d      = 1'b1;
`ifdef CH_TABLE_AGING_EN
            age_d[upd_idx_q] = '0;
`endif
        end

        if (flush) begin
            state_d       = StIdle;
            valid_d       = '0;
            adv_drop_d    = 1'b0;
            tbl_changed_d = |valid_q;
`ifdef CH_TABLE_AGING_EN
            age_d       = '0;
            tick_pend_d = 1'b0;
`endif
        end

        adv_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            adv_ready_q   <= 1'b0;
            req_id_q      <= '0;
            req_q_q       <= '0;
            req_hops_q    <= '0;
            upd_drop_q    <= 1'b0;
            upd_idx_q     <= '0;
            valid_q       <= '0;
            id_q          <= '0;
            q_q           <= '0;
            hops_q        <= '0;
            tbl_changed_q <= 1'b0;
            adv_drop_q    <= 1'b0;
`ifdef CH_TABLE_AGING_EN
            age_q       <= '0;
            tick_pend_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            adv_ready_q   <= adv_ready_d;
            req_id_q      <= req_id_d;
            req_q_q       <= req_q_d;
            req_hops_q    <= req_hops_d;
            upd_drop_q    <= upd_drop_d;
            upd_idx_q     <= upd_idx_d;
            valid_q       <= valid_d;
            id_q          <= id_d;
            q_q           <= q_d;
            hops_q        <= hops_d;
            tbl_changed_q <= tbl_changed_d;
            adv_drop_q    <= adv_drop_d;
`ifdef CH_TABLE_AGING_EN
            age_q       <= age_d;
            tick_pend_q <= tick_pend_d;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            ch_id[i]   = valid_q[i] ? id_q[i]   : ID_NONE;
            ch_q[i]    = valid_q[i] ? q_q[i]    : Q_NONE;
            ch_hops[i] = valid_q[i] ? hops_q[i] : HOP_NONE;
        end
    end

    assign entry_valid = valid_q;
    assign adv_ready   = adv_ready_q;
    assign tbl_changed = tbl_changed_q;
    assign adv_drop    = adv_drop_q;

endmodule

// File: tb/tb_ch_adv_table.sv
// Directed-vector bench for ch_adv_table (4 entries, AGE_LIMIT 16).
module tb_ch_adv_table;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adv_valid = 1'b0;
    logic       adv_ready;
    logic [7:0] adv_id = '0;
    logic [15:0] adv_q = '0;
    logic [7:0] adv_hops = '0;
    logic       tick = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] ch_id   [0:3];
    logic [15:0] ch_q   [0:3];
    logic [7:0] ch_hops [0:3];
    logic [3:0] entry_valid;
    logic       tbl_changed;
    logic       adv_drop;

    int total = 0;
    int bad   = 0;

    ch_adv_table #(
        .NUM_CH    (4),
        .AGE_LIMIT (8'd16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adv_valid   (adv_valid),
        .adv_ready   (adv_ready),
        .adv_id      (adv_id),
        .adv_q       (adv_q),
        .adv_hops    (adv_hops),
        .tick        (tick),
        .flush       (flush),
        .ch_id       (ch_id),
        .ch_q        (ch_q),
        .ch_hops     (ch_hops),
        .entry_valid (entry_valid),
        .tbl_changed (tbl_changed),
        .adv_drop    (adv_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       id;
        logic [15:0]      q;
        logic [7:0]       hops;
        logic             drop;
        logic [0:3]       e_v;
        logic [0:3][7:0]  e_id;
        logic [0:3][15:0] e_q;
        logic [0:3][7:0]  e_h;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [7:0] id, input logic [15:0] q,
                                input logic [7:0] hops, input logic drop,
                                input logic [0:3] ev, input logic [0:3][7:0] eid,
                                input logic [0:3][15:0] eq, input logic [0:3][7:0] eh);
        vec_t v;
        v.id = id; v.q = q; v.hops = hops; v.drop = drop;
        v.e_v = ev; v.e_id = eid; v.e_q = eq; v.e_h = eh;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    // Leaves the bench just after the accepting edge (cycle N).
    task automatic send(input logic [7:0] id, input logic [15:0] q, input logic [7:0] h);
        int n = 0;
        while (!adv_ready && n < 10) begin
            step();
            n++;
        end
        check("ready_before_send", adv_ready, 1);
        adv_valid = 1'b1;
        adv_id    = id;
        adv_q     = q;
        adv_hops  = h;
        step();
        adv_valid = 1'b0;
    endtask

    task automatic check_table(input string tag, input vec_t v);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_entry%0d", tag, i),
                  {31'd0, entry_valid[i], ch_id[i], ch_q[i], ch_hops[i]},
                  {31'd0, v.e_v[i], v.e_id[i], v.e_q[i], v.e_h[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(8'd3, 16'd100, 8'd2, 1'b0, 4'b1000,
                      {8'd3, 8'hFF, 8'hFF, 8'hFF}, {16'd100, 16'd0, 16'd0, 16'd0},
                      {8'd2, 8'hFF, 8'hFF, 8'hFF});
        vecs[1]  = mk(8'd3, 16'd200, 8'd1, 1'b0, 4'b1000,
                      {8'd3, 8'hFF, 8'hFF, 8'hFF}, {16'd200, 16'd0, 16'd0, 16'd0},
                      {8'd1, 8'hFF, 8'hFF, 8'hFF});
        vecs[2]  = mk(8'd7, 16'd50, 8'd5, 1'b0, 4'b1100,
                      {8'd3, 8'd7, 8'hFF, 8'hFF}, {16'd200, 16'd50, 16'd0, 16'd0},
                      {8'd1, 8'd5, 8'hFF, 8'hFF});
        vecs[3]  = mk(8'd8, 16'd60, 8'd5, 1'b0, 4'b1110,
                      {8'd3, 8'd7, 8'd8, 8'hFF}, {16'd200, 16'd50, 16'd60, 16'd0},
                      {8'd1, 8'd5, 8'd5, 8'hFF});
        vecs[4]  = mk(8'd4, 16'd70, 8'd2, 1'b0, 4'b1111,
                      {8'd3, 8'd7, 8'd8, 8'd4}, {16'd200, 16'd50, 16'd60, 16'd70},
                      {8'd1, 8'd5, 8'd5, 8'd2});
        vecs[5]  = mk(8'd3, 16'd30, 8'd3, 1'b0, 4'b1111,
                      {8'd3, 8'd7, 8'd8, 8'd4}, {16'd30, 16'd50, 16'd60, 16'd70},
                      {8'd3, 8'd5, 8'd5, 8'd2});
        vecs[6]  = mk(8'd9, 16'd90, 8'd4, 1'b0, 4'b1111,
                      {8'd3, 8'd9, 8'd8, 8'd4}, {16'd30, 16'd90, 16'd60, 16'd70},
                      {8'd3, 8'd4, 8'd5, 8'd2});
        vecs[7]  = mk(8'd10, 16'd11, 8'd6, 1'b1, 4'b1111,
                      {8'd3, 8'd9, 8'd8, 8'd4}, {16'd30, 16'd90, 16'd60, 16'd70},
                      {8'd3, 8'd4, 8'd5, 8'd2});
        vecs[8]  = mk(8'd11, 16'd12, 8'd5, 1'b1, 4'b1111,
                      {8'd3, 8'd9, 8'd8, 8'd4}, {16'd30, 16'd90, 16'd60, 16'd70},
                      {8'd3, 8'd4, 8'd5, 8'd2});
        vecs[9]  = mk(8'd12, 16'd120, 8'd1, 1'b0, 4'b1111,
                      {8'd3, 8'd9, 8'd12, 8'd4}, {16'd30, 16'd90, 16'd120, 16'd70},
                      {8'd3, 8'd4, 8'd1, 8'd2});
        vecs[10] = mk(8'd13, 16'd130, 8'd3, 1'b0, 4'b1111,
                      {8'd3, 8'd13, 8'd12, 8'd4}, {16'd30, 16'd130, 16'd120, 16'd70},
                      {8'd3, 8'd3, 8'd1, 8'd2});
        vecs[11] = mk(8'd14, 16'd140, 8'd2, 1'b0, 4'b1111,
                      {8'd14, 8'd13, 8'd12, 8'd4}, {16'd140, 16'd130, 16'd120, 16'd70},
                      {8'd2, 8'd3, 8'd1, 8'd2});
        vecs[12] = mk(8'hFF, 16'd5, 8'd0, 1'b1, 4'b1111,
                      {8'd14, 8'd13, 8'd12, 8'd4}, {16'd140, 16'd130, 16'd120, 16'd70},
                      {8'd2, 8'd3, 8'd1, 8'd2});
        vecs[13] = mk(8'd4, 16'd1, 8'd9, 1'b0, 4'b1111,
                      {8'd14, 8'd13, 8'd12, 8'd4}, {16'd140, 16'd130, 16'd120, 16'd1},
                      {8'd2, 8'd3, 8'd1, 8'd9});

        // Reset state
        step();
        step();
        check("rst_entry_valid", entry_valid, 4'b0000);
        check("rst_adv_ready", adv_ready, 0);
        check("rst_sentinel_id", ch_id[0], 8'hFF);
        check("rst_sentinel_q", ch_q[1], 16'h0000);
        check("rst_sentinel_hops", ch_hops[3], 8'hFF);
        check("rst_pulses", {tbl_changed, adv_drop}, 2'b00);
        rst = 1'b0;
        step();
        check("ready_after_rst", adv_ready, 1);

        for (int k = 0; k < NV; k++) begin
            send(vecs[k].id, vecs[k].q, vecs[k].hops);
            check($sformatf("v%0d_ready_n", k), adv_ready, 0);
            step();
            check($sformatf("v%0d_ready_n1", k), adv_ready, 0);
            check($sformatf("v%0d_pulses_n1", k), {tbl_changed, adv_drop}, 2'b00);
            step();
            check($sformatf("v%0d_changed", k), tbl_changed, !vecs[k].drop);
            check($sformatf("v%0d_drop", k), adv_drop, vecs[k].drop);
            check($sformatf("v%0d_ready_n2", k), adv_ready, 1);
            check_table($sformatf("v%0d", k), vecs[k]);
            step();
            check($sformatf("v%0d_pulse_width", k), {tbl_changed, adv_drop}, 2'b00);
        end

        // Flush while in SEARCH
        send(8'd20, 16'd1, 8'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_entry_valid", entry_valid, 4'b0000);
        check("flush_ready", adv_ready, 1);
        check("flush_changed", tbl_changed, 1);
        check("flush_no_drop", adv_drop, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("flush_after%0d", k), {entry_valid, tbl_changed, adv_drop}, 6'd0);
        end

        // Reset during UPDATE
        send(8'd5, 16'd55, 8'd1);
        step();
        step();
        check("pre_rst_entry0", {entry_valid[0], ch_id[0]}, {1'b1, 8'd5});
        step();
        send(8'd6, 16'd66, 8'd2);
        step();
        rst = 1'b1;
        #1;
        check("rst_async_valid", entry_valid, 4'b0000);
        check("rst_async_ready", adv_ready, 0);
        check("rst_async_id", ch_id[0], 8'hFF);
        step();
        rst = 1'b0;
        step();
        check("rst_recover_ready", adv_ready, 1);
        check("rst_discard", {entry_valid, tbl_changed, adv_drop}, 6'd0);

`ifdef CH_TABLE_AGING_EN
        // Expiry on the 16th tick
        send(8'd3, 16'd100, 8'd2);
        step();
        step();
        tick_n(15);
        check("age15_valid", entry_valid[0], 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("age16_valid", entry_valid[0], 0);
        check("age16_id", ch_id[0], 8'hFF);
        check("age16_hops", ch_hops[0], 8'hFF);
        check("age16_changed", tbl_changed, 1);
        step();

        // Refresh write colliding with an expiring tick
        send(8'd3, 16'd1, 8'd1);
        step();
        step();
        tick_n(15);
        send(8'd3, 16'd2, 8'd2);
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("collide_valid", entry_valid[0], 1);
        check("collide_q", ch_q[0], 16'd2);
        check("collide_changed", tbl_changed, 1);
        step();
        tick_n(15);
        check("collide_age_reset", entry_valid[0], 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("collide_reexpire", entry_valid[0], 0);
        step();
`else
        // Ticks have no effect when aging is compiled out
        send(8'd3, 16'd100, 8'd2);
        step();
        step();
        tick_n(20);
        check("noage_valid", entry_valid[0], 1);
        check("noage_id", ch_id[0], 8'd3);
        check("noage_no_pulse", tbl_changed, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ch_adv_table.md
CH_ADV_TABLE -- requirements
Module: ch_adv_table

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: table entries (cluster-head candidates).
REQ-002 SHALL have parameter AGE_LIMIT, default 8'd16: tick count after which an entry expires.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port adv_valid  input  1  received CH advertisement present.
REQ-006 SHALL have port adv_ready  output  1  block can accept an advertisement.
REQ-007 SHALL have ports adv_id / adv_q / adv_hops  input  8 / 16 / 8  advertised CH_ID, Q-value, hop count.
REQ-008 SHALL have port tick  input  1  single-cycle aging strobe.
REQ-009 SHALL have port flush  input  1  clear the whole table.
REQ-010 SHALL have ports ch_id / ch_q / ch_hops  output  [0:NUM_CH-1] x 8 / 16 / 8  table contents feeding the downstream cluster-head selector.
REQ-011 SHALL have port entry_valid  output  NUM_CH  per-entry valid flags.
REQ-012 SHALL have ports tbl_changed / adv_drop  output  1 / 1  single-cycle pulses.

Function
REQ-013 Invalid entries SHALL drive ch_id=8'hFF, ch_q=16'h0000, ch_hops=8'hFF, so the downstream minimum-hop search ignores them.
REQ-014 FSM SHALL have states IDLE, SEARCH, UPDATE; adv_ready=1 only in IDLE.
REQ-015 IDLE->SEARCH on adv_valid && adv_ready; the fields are registered on that edge (cycle N).
REQ-016 SEARCH (N+1) SHALL compare the registered ID with all valid entries in parallel, then compute the first free index and the victim index.
REQ-017 UPDATE (N+2) SHALL write the table and return to IDLE; outputs and tbl_changed reflect the write at N+2.
REQ-018 Matching valid entry: overwrite q and hops, clear age, and pulse tbl_changed.
REQ-019 No match, free slot available: write the lowest-index free entry, set valid, clear age, and pulse tbl_changed.
REQ-020 No match, table full: victim is the lowest-index entry with maximum hops.
REQ-021 On a full table, replace the victim only if adv_hops < victim hops; otherwise pulse adv_drop and leave the table unchanged.
REQ-022 adv_id==8'hFF (reserved sentinel) SHALL be dropped in UPDATE with an adv_drop pulse.
REQ-023 Each valid entry SHALL have a saturating 8-bit age counter, incremented on tick.
REQ-024 An entry whose age reaches AGE_LIMIT SHALL be invalidated on that same edge, pulsing tbl_changed.
REQ-025 If tick and an UPDATE write hit the same entry in the same cycle, the write SHALL win: age=0 and entry valid.
REQ-026 flush SHALL have top priority: invalidate all entries, clear ages, abort any in-flight advertisement (no drop pulse), force IDLE, and pulse tbl_changed if any entry was valid.
REQ-027 tbl_changed and adv_drop SHALL never assert in the same cycle.

Reset
REQ-028 rst SHALL asynchronously force state IDLE, all entry_valid=0, all ages=0, tbl_changed=0, adv_drop=0.
REQ-029 Under rst, all table outputs SHALL show the REQ-013 sentinels and adv_ready=0.
REQ-030 adv_ready SHALL rise on the first clock edge after rst deasserts.
REQ-031 rst asserted mid-operation SHALL discard the in-flight advertisement.

Configuration
REQ-032 Macro CH_TABLE_AGING_EN SHALL control aging.
REQ-033 With CH_TABLE_AGING_EN defined: REQ-023..025 apply.
REQ-034 Without CH_TABLE_AGING_EN: no age counters are synthesized, tick is ignored, and entries persist until replacement, flush or rst.

Structure
REQ-035 Shared package eer_rl_pkg SHALL hold ID/Q/HOP widths, NUM_CH default, the sentinel constants 8'hFF/16'h0000/8'hFF, and the FSM state typedef.
REQ-036 The combinational max-hops victim finder SHALL be sub-module ch_victim_select (inputs hops and valid vectors; output index).

Verification
REQ-037 Insert after reset: adv id=3, q=100, hops=2 -> entry0 = {3,100,2} valid at N+2; tbl_changed pulses once; adv_ready low for 2 cycles.
REQ-038 Refresh: table holds id=3; adv id=3, q=200, hops=1 -> entry0 = {3,200,1}; no second entry allocated.
REQ-039 Full-table replace: entries with hops 3,5,5,2; adv id=9, hops=4 -> entry1 replaced.
REQ-040 Full-table drop: same table, adv hops=6 -> adv_drop pulses; table unchanged.
REQ-041 Aging (macro on): id=3 inserted, 16 ticks -> entry_valid[0]=0 and sentinels on outputs at the 16th tick edge.
REQ-042 Aging collision (macro on): tick coinciding with a refresh of id=3 -> entry stays valid with age 0.
REQ-043 Flush mid-SEARCH: flush -> all entries invalid, no adv_drop, adv_ready=1 next cycle.
REQ-044 rst mid-UPDATE: rst asserted -> all entries invalid immediately.
REQ-045 Reserved ID: adv id=8'hFF -> adv_drop pulses; table unchanged.
